// File: rtl/pet_pkg.sv
// Shared types, command bytes and saturating arithmetic for the pet state engine.
package pet_pkg;

    localparam int unsigned STAT_W = 5;
    localparam logic [STAT_W-1:0] STAT_MAX    = STAT_W'(15);
    localparam logic [STAT_W-1:0] STAT_ONE    = STAT_W'(1);
    localparam logic [STAT_W-1:0] FEED_STEP   = STAT_W'(4);
    localparam logic [STAT_W-1:0] PLAY_STEP   = STAT_W'(4);
    localparam logic [STAT_W-1:0] PLAY_ENERGY = STAT_W'(2);

    localparam logic [7:0] CMD_FEED   = 8'h66;  // 'f'
    localparam logic [7:0] CMD_PLAY   = 8'h70;  // 'p'
    localparam logic [7:0] CMD_CLEAN  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_SLEEP  = 8'h73;  // 's'
    localparam logic [7:0] CMD_REVIVE = 8'h72;  // 'r'

    typedef enum logic [1:0] {
        AWAKE  = 2'd0,
        ASLEEP = 2'd1,
        DEAD   = 2'd2
    } pet_state_t;

    // Add or subtract a step, clamping the result to 0..STAT_MAX.
    function automatic logic [STAT_W-1:0] sat_step(input logic [STAT_W-1:0] v,
                                                   input logic [STAT_W-1:0] d,
                                                   input logic              sub);
        logic [STAT_W:0] t;
        if (sub) begin
            t = (v >= d) ? {1'b0, v - d} : '0;
        end else begin
            t = {1'b0, v} + {1'b0, d};
            if (t > {1'b0, STAT_MAX}) t = {1'b0, STAT_MAX};
        end
        return t[STAT_W-1:0];
    endfunction

    function automatic logic [7:0] fold_case(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
    endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Free-running prescaler producing a one-cycle decay tick each time it wraps.
module pet_tick_gen #(
    parameter int unsigned TICK_CYCLES = 27000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_LAST);
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pet_state_engine.sv
// Pet need counters and sleep/alive state, driven by UART command bytes and periodic decay ticks.
module pet_state_engine
    import pet_pkg::*;
#(
    parameter int unsigned TICK_CYCLES   = 27000000,
    parameter int unsigned HUNGER_TICKS  = 3,
    parameter int unsigned HAPPY_TICKS   = 5,
    parameter int unsigned HYGIENE_TICKS = 7,
    parameter int unsigned ENERGY_TICKS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    output logic [4:0] hunger,
    output logic [4:0] happiness,
    output logic [4:0] hygiene,
    output logic [4:0] energy,
    output logic       is_sleeping,
    output logic       dead,
    output logic       cmd_ack
);

    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] HUNGER_LAST  = DIV_W'(HUNGER_TICKS - 1);
    localparam logic [DIV_W-1:0] HAPPY_LAST   = DIV_W'(HAPPY_TICKS - 1);
    localparam logic [DIV_W-1:0] HYGIENE_LAST = DIV_W'(HYGIENE_TICKS - 1);
    localparam logic [DIV_W-1:0] ENERGY_LAST  = DIV_W'(ENERGY_TICKS - 1);

    pet_state_t       state, state_n;
    logic             tick, tick_pending, tick_pending_n, run_tick;
    logic [7:0]       rx_prev, cmd;
    logic             accept, hit, ack_n;
    logic [4:0]       hunger_n, happiness_n, hygiene_n, energy_n;
    logic [DIV_W-1:0] hunger_div, happy_div, hygiene_div, energy_div;
    logic [DIV_W-1:0] hunger_div_n, happy_div_n, hygiene_div_n, energy_div_n;

    pet_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign accept   = (rx_byte != 8'h00) && (rx_prev == 8'h00);
    assign cmd      = fold_case(rx_byte);
    assign run_tick = tick | tick_pending;

    always_comb begin
        state_n        = state;
        hunger_n       = hunger;
        happiness_n    = happiness;
        hygiene_n      = hygiene;
        energy_n       = energy;
        hunger_div_n   = hunger_div;
        happy_div_n    = happy_div;
        hygiene_div_n  = hygiene_div;
        energy_div_n   = energy_div;
        tick_pending_n = tick_pending;
        ack_n          = 1'b0;
        hit            = 1'b0;

        if (state == DEAD) hit = accept && (cmd == CMD_REVIVE);
        else               hit = accept && (cmd inside {CMD_FEED, CMD_PLAY, CMD_CLEAN, CMD_SLEEP});

        if (hit) begin
            // A tick landing on a command is deferred by one cycle rather than dropped.
            ack_n          = 1'b1;
            tick_pending_n = run_tick;
            case (cmd)
                CMD_FEED:  hunger_n = sat_step(hunger, FEED_STEP, 1'b1);
                CMD_PLAY: begin
                    happiness_n = sat_step(happiness, PLAY_STEP, 1'b1);
                    energy_n    = sat_step(energy, PLAY_ENERGY, 1'b0);
                end
                CMD_CLEAN: hygiene_n = '0;
                CMD_SLEEP: state_n = (state == AWAKE) ? ASLEEP : AWAKE;
                CMD_REVIVE: begin
                    state_n       = AWAKE;
                    hunger_n      = '0;
                    happiness_n   = '0;
                    hygiene_n     = '0;
                    energy_n      = '0;
                    hunger_div_n  = '0;
                    happy_div_n   = '0;
                    hygiene_div_n = '0;
                    energy_div_n  = '0;
                end
                default: ;
            endcase
        end else if (run_tick) begin
            tick_pending_n = 1'b0;
            if (state != DEAD) begin
                if (hunger_div == HUNGER_LAST) begin
                    hunger_div_n = '0;
                    hunger_n     = sat_step(hunger, STAT_ONE, 1'b0);
                end else begin
                    hunger_div_n = hunger_div + 1'b1;
                end
                if (state == AWAKE) begin
                    if (happy_div == HAPPY_LAST) begin
                        happy_div_n = '0;
                        happiness_n = sat_step(happiness, STAT_ONE, 1'b0);
                    end else begin
                        happy_div_n = happy_div + 1'b1;
                    end
                    if (hygiene_div == HYGIENE_LAST) begin
                        hygiene_div_n = '0;
                        hygiene_n     = sat_step(hygiene, STAT_ONE, 1'b0);
                    end else begin
                        hygiene_div_n = hygiene_div + 1'b1;
                    end
                    if (energy_div == ENERGY_LAST) begin
                        energy_div_n = '0;
                        energy_n     = sat_step(energy, STAT_ONE, 1'b0);
                    end else begin
                        energy_div_n = energy_div + 1'b1;
                    end
                end else begin
                    energy_n = sat_step(energy, STAT_ONE, 1'b1);
                    if (energy_n == '0) state_n = AWAKE;
                end
            end
        end

        if (state_n != DEAD && (hunger_n == STAT_MAX || happiness_n == STAT_MAX ||
                                hygiene_n == STAT_MAX || energy_n == STAT_MAX))
            state_n = DEAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= AWAKE;
            hunger       <= '0;
            happiness    <= '0;
            hygiene      <= '0;
            energy       <= '0;
            hunger_div   <= '0;
            happy_div    <= '0;
            hygiene_div  <= '0;
            energy_div   <= '0;
            rx_prev      <= '0;
            tick_pending <= 1'b0;
            is_sleeping  <= 1'b0;
            dead         <= 1'b0;
            cmd_ack      <= 1'b0;
        end else begin
            state        <= state_n;
            hunger       <= hunger_n;
            happiness    <= happiness_n;
            hygiene      <= hygiene_n;
            energy       <= energy_n;
            hunger_div   <= hunger_div_n;
            happy_div    <= happy_div_n;
            hygiene_div  <= hygiene_div_n;
            energy_div   <= energy_div_n;
            rx_prev      <= rx_byte;
            tick_pending <= tick_pending_n;
            is_sleeping  <= (state_n == ASLEEP);
            dead         <= (state_n == DEAD);
            cmd_ack      <= ack_n;
        end
    end

endmodule

// File: tb/tb_pet_state_engine.sv
// Directed bench for pet_state_engine: fast-tick instance for decay/commands, slow-tick instance for held-byte handling.
module tb_pet_state_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte, s_rx_byte;
    logic [4:0] hunger, happiness, hygiene, energy;
    logic [4:0] s_hunger, s_happiness, s_hygiene, s_energy;
    logic       is_sleeping, dead, cmd_ack;
    logic       s_is_sleeping, s_dead, s_cmd_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt   = 0;
    int s_ack_cnt = 0;

    pet_state_engine #(.TICK_CYCLES(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .hunger      (hunger),
        .happiness   (happiness),
        .hygiene     (hygiene),
        .energy      (energy),
        .is_sleeping (is_sleeping),
        .dead        (dead),
        .cmd_ack     (cmd_ack)
    );

    pet_state_engine #(.TICK_CYCLES(1000)) dut_slow (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (s_rx_byte),
        .hunger      (s_hunger),
        .happiness   (s_happiness),
        .hygiene     (s_hygiene),
        .energy      (s_energy),
        .is_sleeping (s_is_sleeping),
        .dead        (s_dead),
        .cmd_ack     (s_cmd_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_ack === 1'b1)   ack_cnt++;
        if (s_cmd_ack === 1'b1) s_ack_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; returns just after a falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag, input int h, input int p, input int g, input int e);
        check_eq({tag, ".hunger"},    32'(hunger),    32'(h));
        check_eq({tag, ".happiness"}, 32'(happiness), 32'(p));
        check_eq({tag, ".hygiene"},   32'(hygiene),   32'(g));
        check_eq({tag, ".energy"},    32'(energy),    32'(e));
    endtask

    initial begin
        rst       = 1'b1;
        rx_byte   = 8'h00;
        s_rx_byte = 8'h00;
        cycles(2);
        check_stats("reset", 0, 0, 0, 0);
        check_eq("reset.sleep", 32'(is_sleeping), 0);
        check_eq("reset.dead",  32'(dead), 0);
        check_eq("reset.ack",   32'(cmd_ack), 0);
        rst = 1'b0;

        // Stat updates land on edges 11, 21, 31, ... after release.
        cycles(35);
        check_stats("3ticks", 1, 0, 0, 0);
        check_eq("3ticks.ack_count", 32'(ack_cnt), 0);

        cycles(170);
        check_stats("20ticks", 6, 4, 2, 5);

        rx_byte = "f"; cycles(1);
        check_eq("feed.hunger", 32'(hunger), 2);
        check_eq("feed.ack", 32'(cmd_ack), 1);
        cycles(1);
        check_eq("feed.ack_drop", 32'(cmd_ack), 0);
        rx_byte = 8'h00; cycles(1);
        rx_byte = "C"; cycles(1);
        check_eq("clean.hygiene", 32'(hygiene), 0);
        check_eq("clean.ack", 32'(cmd_ack), 1);
        rx_byte = 8'h00; cycles(1);
        check_eq("clean.ack_drop", 32'(cmd_ack), 0);
        check_eq("fc.ack_count", 32'(ack_cnt), 2);

        cycles(2);
        check_stats("tick21", 3, 4, 1, 5);
        rx_byte = "s"; cycles(1);
        check_eq("sleep.on", 32'(is_sleeping), 1);
        check_eq("sleep.ack", 32'(cmd_ack), 1);
        rx_byte = 8'h00;
        cycles(47);
        check_eq("sleep.still", 32'(is_sleeping), 1);
        check_stats("sleep4", 4, 4, 1, 1);
        cycles(1);
        check_eq("sleep.autowake", 32'(is_sleeping), 0);
        check_stats("wake", 4, 4, 1, 0);

        // Feed accepted on the same edge a tick is applied.
        cycles(9);
        rx_byte = "f"; cycles(1);
        check_eq("collide.hunger_cmd", 32'(hunger), 0);
        check_eq("collide.ack", 32'(cmd_ack), 1);
        rx_byte = 8'h00; cycles(1);
        check_eq("collide.hunger_tick", 32'(hunger), 1);
        cycles(10);
        check_eq("collide.no_double", 32'(hunger), 1);

        cycles(408);
        check_eq("predead.hunger", 32'(hunger), 14);
        check_eq("predead.dead", 32'(dead), 0);
        cycles(5);
        check_stats("dead", 15, 12, 7, 11);
        check_eq("dead.flag", 32'(dead), 1);
        check_eq("dead.sleep", 32'(is_sleeping), 0);
        cycles(30);
        check_stats("dead.frozen", 15, 12, 7, 11);

        rx_byte = "f"; cycles(1);
        check_eq("dead.feed_ack", 32'(cmd_ack), 0);
        check_eq("dead.feed_hunger", 32'(hunger), 15);
        rx_byte = 8'h00; cycles(1);
        rx_byte = "r"; cycles(1);
        check_eq("revive.ack", 32'(cmd_ack), 1);
        check_eq("revive.dead", 32'(dead), 0);
        check_stats("revive", 0, 0, 0, 0);
        rx_byte = 8'h00; cycles(1);
        rx_byte = "P"; cycles(1);
        check_eq("play.ack", 32'(cmd_ack), 1);
        check_eq("play.energy", 32'(energy), 2);
        rx_byte = 8'h00; cycles(1);
        rx_byte = "x"; cycles(1);
        check_eq("unknown.ack", 32'(cmd_ack), 0);
        rx_byte = 8'h00; cycles(1);
        rx_byte = "r"; cycles(1);
        check_eq("alive_revive.ack", 32'(cmd_ack), 0);
        check_eq("alive_revive.energy", 32'(energy), 2);
        rx_byte = 8'h00;

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst.energy", 32'(energy), 0);
        check_eq("async_rst.sleep", 32'(is_sleeping), 0);
        check_eq("async_rst.dead", 32'(dead), 0);
        cycles(2);
        rst = 1'b0;

        s_rx_byte = "p"; cycles(1);
        check_eq("hold.first_ack", 32'(s_cmd_ack), 1);
        check_eq("hold.energy1", 32'(s_energy), 2);
        cycles(499);
        check_eq("hold.ack_count1", 32'(s_ack_cnt), 1);
        s_rx_byte = 8'h00; cycles(2);
        s_rx_byte = "p"; cycles(1);
        check_eq("hold.second_ack", 32'(s_cmd_ack), 1);
        s_rx_byte = 8'h00; cycles(2);
        check_eq("hold.ack_count2", 32'(s_ack_cnt), 2);
        check_eq("hold.happiness", 32'(s_happiness), 0);
        check_eq("hold.energy2", 32'(s_energy), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
